alu_sequencer: RTL and testbench

Programmable controller for the team's 8-bit ALU/accumulator datapath. It stores a short program of up to eight ALU steps, then on `start` drives the ALU select code and A operand one step at a time, capturing each ALU result into the 8-bit accumulator it owns. The accumulator feeds back to the ALU as B operand (low nibble) and hold value (full byte). The block replaces manual key-clocked stepping of the ALU/register pair.

---
 rtl/alu_pkg.sv | 40 ++++
 rtl/seq_program_store.sv | 40 ++++
 rtl/alu_sequencer.sv | 143 ++++++++++++++
 tb/tb_alu_sequencer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types and constants for the ALU step sequencer
//
// Holds the ALU select codes, the sequencer state encoding, the step word
// layout and the step-count saturation helper.

package alu_pkg;

  localparam int STEP_W = 7;  // step word: {sel[2:0], a[3:0]}
  localparam int ACC_W  = 8;

  typedef enum logic [2:0] {
    SEL_NONE      = 3'b000,
    SEL_HOLD      = 3'b001,
    SEL_CAT_NOTB  = 3'b010,
    SEL_MATCH     = 3'b011,
    SEL_ORRED     = 3'b100,
    SEL_NAND_XNOR = 3'b101,
    SEL_ADD       = 3'b110,
    SEL_RIPPLE    = 3'b111
  } alu_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_EXEC  = 2'b10,
    ST_DONE  = 2'b11
  } seq_state_e;

  // Field positions of a stored step: sel in [6:4], A operand in [3:0].
  typedef struct packed {
    logic [2:0] sel;
    logic [3:0] a;
  } step_t;

  // The program holds eight steps; any request above that runs all eight.
  function automatic logic [3:0] effective_count(input logic [3:0] raw);
    return (raw > 4'd8) ? 4'd8 : raw;
  endfunction

endpackage

// File: rtl/seq_program_store.sv
// rtl/seq_program_store.sv - step program register file, sync write, registered read
//
// Ports:
//   CLK    in   clock
//   we     in   write strobe
//   waddr  in   write slot
//   wdata  in   step word to store
//   re     in   read enable, loads rdata at the rising edge
//   raddr  in   read slot
//   rdata  out  registered step word
//
// No reset: program contents survive reset and persist between runs.

module seq_program_store
  import alu_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic              CLK,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [STEP_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [STEP_W-1:0] rdata
);

  logic [STEP_W-1:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - runs a stored program of ALU steps into an owned accumulator
//
// Ports:
//   CLK         in   system clock, rising edge
//   reset       in   asynchronous active-low reset
//   prog_we     in   program write strobe (IDLE only)
//   prog_addr   in   program slot to write
//   prog_data   in   step word {sel, a}
//   step_count  in   steps to run, sampled with start, saturates at 8
//   start       in   run request (IDLE only)
//   clear       in   accumulator clear (IDLE only)
//   alu_sel     out  ALU select code, SEL_NONE outside EXEC
//   alu_a       out  ALU A operand, 0 outside EXEC
//   alu_b       out  acc[3:0]
//   alu_hold    out  acc
//   alu_result  in   ALU combinational result, captured at the end of EXEC
//   acc         out  accumulator
//   busy        out  high in FETCH and EXEC
//   done        out  one-cycle pulse in DONE

module alu_sequencer
  import alu_pkg::*;
#(
  parameter int STEPS = 8
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             prog_we,
  input  logic [2:0]       prog_addr,
  input  logic [STEP_W-1:0] prog_data,
  input  logic [3:0]       step_count,
  input  logic             start,
  input  logic             clear,
  output logic [2:0]       alu_sel,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [ACC_W-1:0] alu_hold,
  input  logic [ACC_W-1:0] alu_result,
  output logic [ACC_W-1:0] acc,
  output logic             busy,
  output logic             done
);

  seq_state_e        state_q, state_d;
  logic [2:0]        pc_q, pc_d;
  logic [3:0]        count_q, count_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [3:0]        start_count;
  logic              last_step;
  logic              mem_we;
  logic              mem_re;
  logic [STEP_W-1:0] step_word;
  step_t             step;

  assign start_count = effective_count(step_count);
  // EXEC is only reached with count_q >= 1, so the subtraction never wraps there.
  assign last_step   = ({1'b0, pc_q} == (count_q - 4'd1));
  assign mem_we      = (state_q == ST_IDLE) && prog_we;
  assign mem_re      = (state_q == ST_FETCH);
  assign step        = step_t'(step_word);

  seq_program_store #(
    .DEPTH (STEPS),
    .AW    (3)
  ) u_store (
    .CLK   (CLK),
    .we    (mem_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .re    (mem_re),
    .raddr (pc_q),
    .rdata (step_word)
  );

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      pc_q    <= 3'd0;
      count_q <= 4'd0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
      acc_q   <= acc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    count_d = count_q;
    acc_d   = acc_q;
    case (state_q)
      ST_IDLE: begin
        // clear and start may coincide; the cleared acc is what step 0 sees.
        if (clear) begin
          acc_d = '0;
        end
        if (start) begin
          count_d = start_count;
          pc_d    = 3'd0;
          state_d = (start_count != 4'd0) ? ST_FETCH : ST_DONE;
        end
      end
      ST_FETCH: begin
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        acc_d = alu_result;
        if (last_step) begin
          state_d = ST_DONE;
        end else begin
          pc_d    = pc_q + 3'd1;
          state_d = ST_FETCH;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Operand outputs are gated by state, so the unreset step word never leaks out.
  always_comb begin
    alu_sel = SEL_NONE;
    alu_a   = 4'd0;
    if (state_q == ST_EXEC) begin
      alu_sel = step.sel;
      alu_a   = step.a;
    end
  end

  assign busy     = (state_q == ST_FETCH) || (state_q == ST_EXEC);
  assign done     = (state_q == ST_DONE);
  assign acc      = acc_q;
  assign alu_b    = acc_q[3:0];
  assign alu_hold = acc_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - self-checking bench for alu_sequencer with an ALU model

module tb_alu_sequencer;
  import alu_pkg::*;

  logic       CLK;
  logic       reset;
  logic       prog_we;
  logic [2:0] prog_addr;
  logic [6:0] prog_data;
  logic [3:0] step_count;
  logic       start;
  logic       clear;
  logic [2:0] alu_sel;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [7:0] alu_hold;
  logic [7:0] alu_result;
  logic [7:0] acc;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q [$];

  typedef struct packed {
    logic [0:7][6:0] prog;
    logic [3:0]      count;
    logic            do_clear;
    logic [7:0]      exp_acc;
  } vec_t;

  vec_t vecs [10];

  alu_sequencer #(.STEPS(8)) dut (
    .CLK        (CLK),
    .reset      (reset),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .step_count (step_count),
    .start      (start),
    .clear      (clear),
    .alu_sel    (alu_sel),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_hold   (alu_hold),
    .alu_result (alu_result),
    .acc        (acc),
    .busy       (busy),
    .done       (done)
  );

  // Team ALU stand-in.
  always_comb begin
    alu_result = 8'h00;
    case (alu_sel)
      3'b001:  alu_result = alu_hold;
      3'b010:  alu_result = {alu_a, ~alu_b};
      3'b011:  alu_result = {7'd0, alu_a == alu_b};
      3'b100:  alu_result = {7'd0, |{alu_a, alu_b}};
      3'b101:  alu_result = {~(alu_a & alu_b), ~(alu_a ^ alu_b)};
      3'b110:  alu_result = {3'd0, {1'b0, alu_a} + {1'b0, alu_b}};
      3'b111:  alu_result = {4'd0, alu_a ^ alu_b};
      default: alu_result = 8'h00;
    endcase
  end

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic vec_t mk(input logic [6:0] p0, input logic [6:0] p1,
                              input logic [6:0] p2, input logic [6:0] p3,
                              input logic [6:0] p4, input logic [6:0] p5,
                              input logic [6:0] p6, input logic [6:0] p7,
                              input logic [3:0] c, input logic clr,
                              input logic [7:0] e);
    vec_t v;
    v.prog[0]  = p0;
    v.prog[1]  = p1;
    v.prog[2]  = p2;
    v.prog[3]  = p3;
    v.prog[4]  = p4;
    v.prog[5]  = p5;
    v.prog[6]  = p6;
    v.prog[7]  = p7;
    v.count    = c;
    v.do_clear = clr;
    v.exp_acc  = e;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic write_slot(input logic [2:0] a, input logic [6:0] d);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = d;
    @(negedge CLK);
    prog_we   = 1'b0;
  endtask

  task automatic launch(input logic [3:0] cnt, input logic clr, input logic [7:0] e);
    step_count = cnt;
    clear      = clr;
    start      = 1'b1;
    exp_q.push_back(e);
    @(negedge CLK);
    start      = 1'b0;
    clear      = 1'b0;
  endtask

  // Entered just after edge first_edge of a run; waits for done with a bound.
  task automatic finish_run(input string name, input int n_eff, input int first_edge);
    int edges = first_edge;
    int busy_edges = 0;
    while (done !== 1'b1 && edges < 40) begin
      if (busy === 1'b1) busy_edges++;
      @(negedge CLK);
      edges++;
    end
    chk({name, " done edge"}, edges, 2 * n_eff);
    chk({name, " busy edges"}, busy_edges, 2 * n_eff - first_edge);
    chk({name, " scoreboard depth"}, exp_q.size(), 1);
    if (exp_q.size() != 0) chk({name, " acc"}, acc, exp_q.pop_front());
    @(negedge CLK);
    chk({name, " done width"}, done, 0);
  endtask

  initial begin
    int n_eff;
    reset      = 1'b1;
    prog_we    = 1'b0;
    prog_addr  = 3'd0;
    prog_data  = 7'd0;
    step_count = 4'd0;
    start      = 1'b0;
    clear      = 1'b0;
    #2 reset = 1'b0;
    @(negedge CLK);
    chk("reset acc", acc, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset alu_sel", alu_sel, 0);
    chk("reset alu_a", alu_a, 0);
    reset = 1'b1;
    @(negedge CLK);

    // Two-step add, edge by edge.
    write_slot(3'd0, 7'h63);
    write_slot(3'd1, 7'h65);
    step_count = 4'd2; clear = 1'b1; start = 1'b1;
    @(negedge CLK);
    start = 1'b0; clear = 1'b0;
    chk("add e0 busy", busy, 1);
    chk("add e0 alu_sel", alu_sel, 0);
    @(negedge CLK);
    chk("add e1 alu_sel", alu_sel, 3'b110);
    chk("add e1 alu_a", alu_a, 3);
    @(negedge CLK);
    chk("add e2 acc", acc, 8'h03);
    chk("add e2 done", done, 0);
    @(negedge CLK);
    chk("add e3 alu_a", alu_a, 5);
    chk("add e3 alu_b", alu_b, 3);
    @(negedge CLK);
    chk("add e4 acc", acc, 8'h08);
    chk("add e4 done", done, 1);
    chk("add e4 busy", busy, 0);
    @(negedge CLK);
    chk("add e5 done", done, 0);

    // Build acc = 0x5C, then a zero-count run.
    write_slot(3'd0, 7'h63);
    write_slot(3'd1, 7'h25);
    launch(4'd2, 1'b1, 8'h5C);
    finish_run("set5c", 2, 0);
    step_count = 4'd0; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    chk("zero e0 done", done, 1);
    chk("zero e0 busy", busy, 0);
    chk("zero e0 alu_sel", alu_sel, 0);
    chk("zero e0 acc", acc, 8'h5C);
    @(negedge CLK);
    chk("zero e1 done", done, 0);
    chk("zero e1 acc", acc, 8'h5C);

    // Inputs pulsed while busy must be dropped.
    write_slot(3'd0, 7'h10);
    write_slot(3'd1, 7'h10);
    write_slot(3'd2, 7'h10);
    launch(4'd3, 1'b0, 8'h5C);
    @(negedge CLK);
    prog_we = 1'b1; prog_addr = 3'd0; prog_data = 7'h6F;
    clear = 1'b1; start = 1'b1; step_count = 4'd1;
    @(negedge CLK);
    prog_we = 1'b0; clear = 1'b0; start = 1'b0;
    finish_run("busy_ignore", 3, 2);
    for (int i = 0; i < 4; i++) begin
      chk("no rerun busy", busy, 0);
      chk("no rerun done", done, 0);
      @(negedge CLK);
    end
    launch(4'd1, 1'b0, 8'h5C);
    @(negedge CLK);
    chk("readback sel", alu_sel, 3'b001);
    chk("readback a", alu_a, 0);
    finish_run("readback", 1, 1);

    // Reset between edges 3 and 4 of a 4-step add.
    for (int s = 0; s < 4; s++) write_slot(s[2:0], 7'h61);
    launch(4'd4, 1'b1, 8'h04);
    repeat (3) @(negedge CLK);
    reset = 1'b0;
    #1;
    chk("midreset acc", acc, 0);
    chk("midreset busy", busy, 0);
    chk("midreset alu_sel", alu_sel, 0);
    chk("midreset done", done, 0);
    exp_q.delete();
    @(negedge CLK);
    chk("held reset done", done, 0);
    @(negedge CLK);
    reset = 1'b1;
    @(negedge CLK);
    chk("post reset done", done, 0);
    chk("post reset busy", busy, 0);
    launch(4'd4, 1'b0, 8'h04);
    finish_run("rerun", 4, 0);

    // Table of whole runs; acc chains from one vector to the next.
    vecs[0] = mk(7'h63, 7'h65, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 4'd2,  1'b1, 8'h08);
    vecs[1] = mk(7'h2A, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 4'd1,  1'b0, 8'hA7);
    vecs[2] = mk(7'h63, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 4'd0,  1'b0, 8'hA7);
    vecs[3] = mk(7'h10, 7'h10, 7'h10, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 4'd3,  1'b0, 8'hA7);
    vecs[4] = mk(7'h61, 7'h61, 7'h61, 7'h61, 7'h61, 7'h61, 7'h61, 7'h61, 4'd12, 1'b1, 8'h08);
    vecs[5] = mk(7'h61, 7'h61, 7'h61, 7'h61, 7'h61, 7'h61, 7'h61, 7'h61, 4'd15, 1'b0, 8'h10);
    vecs[6] = mk(7'h25, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 4'd1,  1'b1, 8'h5F);
    vecs[7] = mk(7'h67, 7'h23, 7'h62, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 4'd3,  1'b1, 8'h0A);
    vecs[8] = mk(7'h67, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 4'd0,  1'b1, 8'h00);
    vecs[9] = mk(7'h61, 7'h61, 7'h61, 7'h61, 7'h61, 7'h61, 7'h61, 7'h61, 4'd9,  1'b0, 8'h08);
    for (int i = 0; i < 10; i++) begin
      for (int s = 0; s < 8; s++) write_slot(s[2:0], vecs[i].prog[s]);
      n_eff = (vecs[i].count > 4'd8) ? 8 : int'(vecs[i].count);
      launch(vecs[i].count, vecs[i].do_clear, vecs[i].exp_acc);
      finish_run($sformatf("vec%0d", i), n_eff, 0);
    end

    chk("scoreboard drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
